mem_xbar_n: RTL and testbench
=============================

# mem_xbar_n

Parametrised, registered successor to the two-way data/MMIO crossbar. It routes one master load/store port to N address regions, each with its own request/acknowledge handshake, so slow peripherals can insert wait states. Unmapped accesses and slave timeouts return a bus error, and the first faulting address is captured. It sits between the CPU load/store unit and the data memory and MMIO slaves, with one transaction outstanding at a time.

## Interface
Parameters:
- `N_REGIONS`, 2, number of slave regions (1..8).
- `AW`, 30, word-address width.
- `DW`, 32, data width; mask width `MW = DW/8`.
- `REGION_BASE`, {30'h0000_4000, 30'h0000_0000}, packed `N_REGIONS*AW`; region k occupies bits [k*AW +: AW].
- `REGION_LIMIT`, {30'h0000_4100, 30'h0000_0400}, packed like `REGION_BASE`; the limit is exclusive.
- `TIMEOUT`, 15, maximum number of BUSY cycles to wait for a slave ack; 0 disables the timeout.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_req`  in  1  master request; sampled only in IDLE.
- `i_addr`  in  AW  master word address.
- `i_data`  in  DW  master write data.
- `i_wren`  in  1  1 = write, 0 = read.
- `i_mask`  in  MW  byte-enable mask.
- `o_ack`  out  1  one-cycle response strobe.
- `o_err`  out  1  qualifies `o_ack` as a bus error.
- `o_data`  out  DW  registered read data; valid while `o_ack`=1.
- `o_s_req`  out  N_REGIONS  one-hot slave request.
- `o_s_addr`  out  N_REGIONS*AW  per-region offset address, `addr - REGION_BASE[k]`; 0 for unselected regions.
- `o_s_data`  out  DW  latched write data, shared by all slaves.
- `o_s_mask`  out  MW  latched mask, shared by all slaves.
- `o_s_wren`  out  N_REGIONS  per-region write enable; nonzero only together with `o_s_req`.
- `i_s_ack`  in  N_REGIONS  per-region acknowledge.
- `i_s_data`  in  N_REGIONS*DW  per-region read data; valid while the matching ack is high.
- `o_fault_valid`  out  1  sticky fault flag.
- `o_fault_addr`  out  AW  address of the first fault.
- `i_fault_clr`  in  1  clears the fault flag and address.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE with `i_req`=1, address decode:
  - Region k hits when `REGION_BASE[k] <= i_addr < REGION_LIMIT[k]`, compared unsigned at full AW width.
  - If regions overlap, the lowest index wins.
- IDLE with a hit:
  - Latch addr, data, mask, wren and region index k; go to BUSY.
- IDLE with no hit:
  - Go to RESP with error; no slave sees a request.
- BUSY:
  - Drive `o_s_req[k]`=1, `o_s_wren[k]`=latched wren, and the latched offset, data and mask.
  - On `i_s_ack[k]`: capture `i_s_data[k]` into the `o_data` register (reads only; writes capture 0); go to RESP, no error.
  - Acks on any index other than k are ignored.
- Timeout:
  - The BUSY cycle counter starts at 1 on entry to BUSY.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` without an ack, drop the request and go to RESP with error.
  - An ack in the expiry cycle wins; no error is raised.
- RESP:
  - `o_ack`=1 and `o_err`=error flag for exactly one cycle, then IDLE.
  - `i_req` is ignored in BUSY and RESP.
- On error:
  - `o_data`=0.
  - If `o_fault_valid`=0, set it and load `o_fault_addr` with the full master address.
  - Later faults do not overwrite a held fault.
- `i_fault_clr`:
  - Clears the flag and address.
  - If it coincides with a new fault, the new fault is captured.

## Timing
- Reset value of every output and state register is 0; the FSM resets to IDLE.
- Reset mid-transaction aborts it: `o_s_req` is 0 in the next cycle and no `o_ack` is issued.
- Unmapped access: `i_req` in cycle t gives `o_ack`/`o_err` in t+1.
- Mapped access, slave acks in its first BUSY cycle: `i_req` in cycle t, `o_s_req` in t+1, ack in t+1, `o_ack` in t+2.
- Each additional wait cycle adds 1 to the latency.
- Timeout: `o_s_req` is high for `TIMEOUT` cycles, and `o_ack`/`o_err` follow in the next cycle.
- Minimum request spacing is 3 cycles for mapped accesses and 2 for unmapped accesses.
- Slave outputs are registered, with no combinational path from `i_addr` to `o_s_*`.
- The `i_s_data` to `o_data` path is registered.

## Test plan
- Read at 0x10 (region 0), slave acks in the same cycle with 0xDEADBEEF:
  - `o_s_addr[0]`=0x10 in t+1.
  - `o_ack` in t+2 with `o_data`=0xDEADBEEF and `o_err`=0.
- Write at 0x4005, mask 4'b0011, slave 1 acks after 3 wait cycles:
  - `o_s_wren[1]`=1 and offset 0x5 are held for 4 cycles.
  - `o_ack` arrives 5 cycles after `i_req`, with `o_data`=0.
- Access to 0x2000 (unmapped):
  - `o_ack`=`o_err`=1 at t+1, and `o_s_req` stays 0.
  - `o_fault_addr`=0x2000 with valid=1.
  - A second fault at 0x3000 leaves the address at 0x2000.
  - `i_fault_clr` clears both.
- Slave 1 never acks, `TIMEOUT`=15:
  - `o_s_req[1]` is high for exactly 15 cycles.
  - Error `o_ack` in the 16th cycle after `o_s_req` rose.
  - The same test with an ack in the 15th cycle gives no error.
- Overlap config, region 0 [0,0x100) and region 1 [0x80,0x200), access to 0x90:
  - Routed to region 0.
- `i_rst` asserted in the second BUSY cycle:
  - Next cycle all outputs are 0.
  - No `o_ack`, and the FSM is in IDLE and accepts a new request.

Source files
------------

// File: rtl/mem_xbar_n.sv
// Registered single-master crossbar routing load/store accesses to N address regions with
// per-region req/ack handshakes, a BUSY timeout, and sticky first-fault address capture.
module mem_xbar_n #(
  parameter int unsigned             N_REGIONS    = 2,
  parameter int unsigned             AW           = 30,
  parameter int unsigned             DW           = 32,
  parameter int unsigned             MW           = DW / 8,
  parameter logic [N_REGIONS*AW-1:0] REGION_BASE  = {30'h0000_4000, 30'h0000_0000},
  parameter logic [N_REGIONS*AW-1:0] REGION_LIMIT = {30'h0000_4100, 30'h0000_0400},
  parameter int unsigned             TIMEOUT      = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic [AW-1:0]           i_addr,
  input  logic [DW-1:0]           i_data,
  input  logic                    i_wren,
  input  logic [MW-1:0]           i_mask,
  output logic                    o_ack,
  output logic                    o_err,
  output logic [DW-1:0]           o_data,
  output logic [N_REGIONS-1:0]    o_s_req,
  output logic [N_REGIONS*AW-1:0] o_s_addr,
  output logic [DW-1:0]           o_s_data,
  output logic [MW-1:0]           o_s_mask,
  output logic [N_REGIONS-1:0]    o_s_wren,
  input  logic [N_REGIONS-1:0]    i_s_ack,
  input  logic [N_REGIONS*DW-1:0] i_s_data,
  output logic                    o_fault_valid,
  output logic [AW-1:0]           o_fault_addr,
  input  logic                    i_fault_clr
);

  localparam int unsigned IW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        r_state;
  logic [IW-1:0] r_idx;
  logic [AW-1:0] r_addr;
  logic          r_wren;
  logic [CW-1:0] r_cnt;

  logic                    w_hit;
  logic [IW-1:0]           w_idx;
  logic [N_REGIONS-1:0]    w_onehot;
  logic [N_REGIONS*AW-1:0] w_s_addr;
  logic                    w_ack;
  logic [DW-1:0]           w_sdata;
  logic                    w_timeout;
  logic                    w_fault_set;
  logic [AW-1:0]           w_fault_addr;

  // Lowest matching region wins when regions overlap.
  always_comb begin
    w_hit    = 1'b0;
    w_idx    = '0;
    w_onehot = '0;
    w_s_addr = '0;
    for (int k = 0; k < N_REGIONS; k++) begin
      if (!w_hit && (i_addr >= REGION_BASE[k*AW +: AW]) &&
          (i_addr < REGION_LIMIT[k*AW +: AW])) begin
        w_hit                 = 1'b1;
        w_idx                 = IW'(k);
        w_onehot[k]           = 1'b1;
        w_s_addr[k*AW +: AW]  = i_addr - REGION_BASE[k*AW +: AW];
      end
    end
  end

  always_comb begin
    w_ack        = i_s_ack[r_idx];
    w_sdata      = i_s_data[r_idx*DW +: DW];
    w_timeout    = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
    w_fault_set  = ((r_state == StIdle) && i_req && !w_hit) ||
                   ((r_state == StBusy) && !w_ack && w_timeout);
    w_fault_addr = (r_state == StIdle) ? i_addr : r_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_addr        <= '0;
      r_wren        <= 1'b0;
      r_cnt         <= '0;
      o_ack         <= 1'b0;
      o_err         <= 1'b0;
      o_data        <= '0;
      o_s_req       <= '0;
      o_s_addr      <= '0;
      o_s_data      <= '0;
      o_s_mask      <= '0;
      o_s_wren      <= '0;
      o_fault_valid <= 1'b0;
      o_fault_addr  <= '0;
    end else begin
      // A clear coinciding with a new fault still captures the new fault.
      if (w_fault_set && (!o_fault_valid || i_fault_clr)) begin
        o_fault_valid <= 1'b1;
        o_fault_addr  <= w_fault_addr;
      end else if (i_fault_clr) begin
        o_fault_valid <= 1'b0;
        o_fault_addr  <= '0;
      end

      case (r_state)
        StIdle: begin
          if (i_req) begin
            if (w_hit) begin
              r_state  <= StBusy;
              r_idx    <= w_idx;
              r_addr   <= i_addr;
              r_wren   <= i_wren;
              r_cnt    <= CW'(1);
              o_s_req  <= w_onehot;
              o_s_wren <= i_wren ? w_onehot : '0;
              o_s_addr <= w_s_addr;
              o_s_data <= i_data;
              o_s_mask <= i_mask;
            end else begin
              r_state <= StResp;
              o_ack   <= 1'b1;
              o_err   <= 1'b1;
              o_data  <= '0;
            end
          end
        end
        StBusy: begin
          if (w_ack || w_timeout) begin
            r_state  <= StResp;
            o_ack    <= 1'b1;
            o_err    <= !w_ack;
            o_data   <= (w_ack && !r_wren) ? w_sdata : '0;
            o_s_req  <= '0;
            o_s_wren <= '0;
            o_s_addr <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StResp: begin
          r_state <= StIdle;
          o_ack   <= 1'b0;
          o_err   <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xbar_n.sv
// Randomized scoreboard bench for mem_xbar_n: stimulus pushes expected responses derived from
// a region-map model; a monitor checks slave-side signals and pops on every master ack.
module tb_mem_xbar_n;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned TO = 15;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [AW-1:0] base_a[N] = '{30'h0, 30'h4000};
  logic [AW-1:0] lim_a[N]  = '{30'h400, 30'h4100};

  logic            clk = 1'b0;
  logic            rst, req, wren, fclr;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic [MW-1:0]   mask;
  logic            ack, err, fv;
  logic [DW-1:0]   rdata, s_data;
  logic [N-1:0]    s_req, s_wren, s_ack;
  logic [N*AW-1:0] s_addr;
  logic [MW-1:0]   s_mask;
  logic [N*DW-1:0] s_rdata;
  logic [AW-1:0]   fa;

  // Second instance with overlapping regions.
  logic            b_req, b_ack, b_err, b_fv, b_fclr;
  logic [AW-1:0]   b_addr, b_fa;
  logic [DW-1:0]   b_rdata, b_s_data;
  logic [N-1:0]    b_s_req, b_s_wren, b_s_ack;
  logic [N*AW-1:0] b_s_addr;
  logic [MW-1:0]   b_s_mask;
  logic [N*DW-1:0] b_s_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  resp_t exp_q[$];

  int            cur_k = -1;
  int            cur_wait = 0;
  logic          cur_wren = 1'b0;
  logic [AW-1:0] cur_off = '0;
  logic [DW-1:0] cur_data = '0;
  logic [MW-1:0] cur_mask = '0;
  logic [DW-1:0] cur_sdata = '0;
  int            req_cycles = 0;
  logic          m_fv = 1'b0;
  logic [AW-1:0] m_fa = '0;

  always #5 clk = ~clk;

  mem_xbar_n #(
    .N_REGIONS(N), .AW(AW), .DW(DW), .MW(MW),
    .REGION_BASE({30'h4000, 30'h0}), .REGION_LIMIT({30'h4100, 30'h400}), .TIMEOUT(TO)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr), .i_data(data), .i_wren(wren),
    .i_mask(mask), .o_ack(ack), .o_err(err), .o_data(rdata), .o_s_req(s_req),
    .o_s_addr(s_addr), .o_s_data(s_data), .o_s_mask(s_mask), .o_s_wren(s_wren),
    .i_s_ack(s_ack), .i_s_data(s_rdata), .o_fault_valid(fv), .o_fault_addr(fa),
    .i_fault_clr(fclr)
  );

  mem_xbar_n #(
    .N_REGIONS(N), .AW(AW), .DW(DW), .MW(MW),
    .REGION_BASE({30'h80, 30'h0}), .REGION_LIMIT({30'h200, 30'h100}), .TIMEOUT(4)
  ) u_ovl (
    .i_clk(clk), .i_rst(rst), .i_req(b_req), .i_addr(b_addr), .i_data(32'h0),
    .i_wren(1'b0), .i_mask(4'hF), .o_ack(b_ack), .o_err(b_err), .o_data(b_rdata),
    .o_s_req(b_s_req), .o_s_addr(b_s_addr), .o_s_data(b_s_data), .o_s_mask(b_s_mask),
    .o_s_wren(b_s_wren), .i_s_ack(b_s_ack), .i_s_data(b_s_rdata), .o_fault_valid(b_fv),
    .o_fault_addr(b_fa), .i_fault_clr(b_fclr)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int k = 0; k < N; k++) if (a >= base_a[k] && a < lim_a[k]) return k;
    return -1;
  endfunction

  function automatic int busy_len(input int wt);
    return (wt + 1 < TO) ? wt + 1 : TO;
  endfunction

  // Slave responder: acks region cur_k in its (cur_wait+1)-th BUSY cycle, junk acks elsewhere.
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    s_ack    = '0;
    s_rdata  = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        s_rdata[k*DW +: DW] = $urandom;
        s_ack[k]            = ($urandom_range(0, 3) == 0);
      end
      if (s_req != '0) begin
        busy_cnt++;
        if (cur_k >= 0) begin
          s_ack[cur_k] = (busy_cnt == cur_wait + 1);
          if (busy_cnt == cur_wait + 1) s_rdata[cur_k*DW +: DW] = cur_sdata;
        end
      end else begin
        busy_cnt = 0;
        if (cur_k >= 0) s_ack[cur_k] = 1'b0;
      end
    end
  end

  // Monitor: slave-side signals during BUSY, scoreboard pop on every master ack.
  initial begin
    logic [N*AW-1:0] ev;
    logic [N-1:0]    oh;
    resp_t           r;
    forever begin
      @(negedge clk);
      if (s_req != '0) begin
        req_cycles++;
        ev = '0;
        oh = '0;
        if (cur_k >= 0) begin
          ev[cur_k*AW +: AW] = cur_off;
          oh[cur_k]          = 1'b1;
        end
        check("s_req", s_req, oh);
        check("s_addr", s_addr, ev);
        check("s_wren", s_wren, cur_wren ? oh : '0);
        check("s_data", s_data, cur_data);
        check("s_mask", s_mask, cur_mask);
      end
      if (ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: o_ack=1 err=%0b with no response expected", err);
        end else begin
          r = exp_q.pop_front();
          check("o_err", err, r.err);
          check("o_data", rdata, r.data);
        end
      end
    end
  end

  task automatic access(input logic [AW-1:0] a, input logic w, input logic [MW-1:0] m,
                        input int wt, input logic [DW-1:0] sd, input logic clr);
    int   k, lat, exp_len;
    logic e;
    resp_t r;
    k = decode(a);
    e = (k < 0) || (wt >= int'(TO));
    cur_k     = k;
    cur_wait  = wt;
    cur_wren  = w;
    cur_data  = $urandom;
    cur_mask  = m;
    cur_sdata = sd;
    cur_off   = (k >= 0) ? a - base_a[k] : '0;
    r.err  = e;
    r.data = (e || w) ? 32'h0 : sd;
    exp_q.push_back(r);
    if (k < 0) begin
      if (clr || !m_fv) begin m_fv = 1'b1; m_fa = a; end
    end else begin
      if (clr) begin m_fv = 1'b0; m_fa = '0; end
      if (e && !m_fv) begin m_fv = 1'b1; m_fa = a; end
    end
    exp_len    = (k < 0) ? 0 : busy_len(wt);
    req_cycles = 0;
    req = 1'b1; addr = a; data = cur_data; wren = w; mask = m; fclr = clr;
    @(posedge clk); #1;
    req = 1'b0; fclr = 1'b0;
    addr = $urandom; data = $urandom; wren = $urandom_range(0, 1); mask = $urandom;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (ack) break;
    end
    check("latency", lat, (k < 0) ? 1 : exp_len + 1);
    check("req_cycles", req_cycles, exp_len);
    check("fault_valid", fv, m_fv);
    check("fault_addr", fa, m_fa);
    @(posedge clk); #1;
  endtask

  task automatic clear_fault();
    fclr = 1'b1;
    @(posedge clk); #1;
    fclr = 1'b0;
    m_fv = 1'b0; m_fa = '0;
    @(negedge clk);
    check("clr_valid", fv, 1'b0);
    check("clr_addr", fa, '0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, {ack, err}, 2'b00);
    check({tag, "_s_req"}, {s_req, s_wren}, '0);
    check({tag, "_s_addr"}, s_addr, '0);
    check({tag, "_s_dm"}, {s_data, s_mask}, '0);
    check({tag, "_data"}, rdata, '0);
    check({tag, "_fault"}, {fv, fa}, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] bnd[6] = '{30'h3FF, 30'h400, 30'h3FFF, 30'h4000, 30'h40FF, 30'h4100};
    logic [AW-1:0] a;
    int            wt;
    rst = 1'b1; req = 1'b0; addr = '0; data = '0; wren = 1'b0; mask = '0; fclr = 1'b0;
    b_req = 1'b0; b_addr = '0; b_fclr = 1'b0; b_s_ack = '0; b_s_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    access(30'h10, 1'b0, 4'hF, 0, 32'hDEADBEEF, 1'b0);
    access(30'h4005, 1'b1, 4'b0011, 3, 32'h12345678, 1'b0);
    access(30'h2000, 1'b0, 4'hF, 0, 32'h0, 1'b0);
    access(30'h3000, 1'b1, 4'hF, 0, 32'h0, 1'b0);
    clear_fault();
    access(30'h2100, 1'b0, 4'hF, 0, 32'h0, 1'b0);
    access(30'h3000, 1'b0, 4'hF, 0, 32'h0, 1'b1);
    clear_fault();
    access(30'h4010, 1'b0, 4'hF, 255, 32'h0, 1'b0);
    access(30'h4020, 1'b0, 4'hF, 14, 32'hCAFEF00D, 1'b0);
    access(30'h4030, 1'b0, 4'hF, 15, 32'h0, 1'b0);

    // Reset during the second BUSY cycle aborts without an ack.
    cur_k = 1; cur_wait = 255; cur_wren = 1'b0; cur_off = 30'h10;
    cur_data = 32'hA5A5A5A5; cur_mask = 4'hF; req_cycles = 0;
    req = 1'b1; addr = 30'h4010; data = cur_data; wren = 1'b0; mask = 4'hF;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_fv = 1'b0; m_fa = '0;
    @(negedge clk);
    check_all_zero("midrst");
    check("midrst_req_cycles", req_cycles, 2);
    repeat (4) @(posedge clk);
    #1;
    access(30'h10, 1'b0, 4'hF, 1, 32'h0BADF00D, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 30'($urandom_range(0, 32'h3FF));
        1: a = 30'h4000 + 30'($urandom_range(0, 32'hFF));
        2: a = 30'($urandom);
        default: a = bnd[$urandom_range(0, 5)];
      endcase
      case ($urandom_range(0, 7))
        0: wt = 14;
        1: wt = 15;
        2: wt = 255;
        default: wt = $urandom_range(0, 3);
      endcase
      access(a, 1'($urandom_range(0, 1)), 4'($urandom), wt, $urandom,
             ($urandom_range(0, 7) == 0));
    end

    // Overlap: 0x90 lies in both regions, region 0 must win.
    b_addr = 30'h90; b_req = 1'b1;
    @(posedge clk); #1 b_req = 1'b0;
    @(negedge clk);
    check("ovl_s_req", b_s_req, 2'b01);
    check("ovl_s_addr", b_s_addr, {30'h0, 30'h90});
    b_s_ack = 2'b11; b_s_rdata = {32'h2222_2222, 32'h1111_1111};
    @(negedge clk);
    check("ovl_ack", {b_ack, b_err}, 2'b10);
    check("ovl_data", b_rdata, 32'h1111_1111);
    b_s_ack = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1 b_addr = 30'h150; b_req = 1'b1;
    @(posedge clk); #1 b_req = 1'b0;
    @(negedge clk);
    check("ovl1_s_req", b_s_req, 2'b10);
    check("ovl1_s_addr", b_s_addr, {30'hD0, 30'h0});
    repeat (8) @(posedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
